dm_arbiter: RTL and testbench



---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_arb_rr_pick.sv | 33 +++
 rtl/dm_arbiter.sv | 139 +++++++++++++
 tb/tb_dm_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  localparam int unsigned ST_W = 3;

  // Sequencer states; encoding is fixed so it can be probed externally.
  typedef enum logic [ST_W-1:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    RD2  = 3'd4
  } arb_state_e;

  // Requester port indices.
  localparam logic P_CPU = 1'b0;
  localparam logic P_DMA = 1'b1;

endpackage

// File: rtl/dm_arb_rr_pick.sv
// Two-way winner selector. Round-robin on a tie by default; with
// DM_ARB_FIXED_PRIO_EN defined, port 0 always wins a tie.
module dm_arb_rr_pick
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_req
);

`ifdef DM_ARB_FIXED_PRIO_EN
  // Tie history is irrelevant when port 0 has fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Port 1 only wins when port 0 is not asking.
  always_comb begin
    any_req = |req;
    grant   = P_CPU;
    if (req == 2'b10) grant = P_DMA;
  end
`else
  // On a tie the port that was not served last wins.
  always_comb begin
    any_req = |req;
    grant   = P_CPU;
    if (req == 2'b10)      grant = P_DMA;
    else if (req == 2'b11) grant = ~last_grant;
  end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Port 0 = CPU MEM stage, port 1 = DMA/loader. Writes ack one cycle after
// grant; reads ack three cycles after grant with data taken from the DM.
// Tie policy selected by DM_ARB_FIXED_PRIO_EN (see dm_arb_rr_pick).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned bit_size = 32,
  parameter int unsigned mem_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [mem_size-1:0] p0_addr,
  input  logic [bit_size-1:0] p0_wdata,
  output logic                p0_ack,
  output logic [bit_size-1:0] p0_rdata,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [mem_size-1:0] p1_addr,
  input  logic [bit_size-1:0] p1_wdata,
  output logic                p1_ack,
  output logic [bit_size-1:0] p1_rdata,
  output logic [mem_size-1:0] DM_Address,
  output logic                DM_en_Read,
  output logic                DM_en_Write,
  output logic [bit_size-1:0] DM_Write_Data,
  input  logic [bit_size-1:0] DM_Read_Data,
  output logic                busy
);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [mem_size-1:0] addr_q, addr_d;
  logic [bit_size-1:0] wdata_q, wdata_d;
  logic [1:0]          ack_q, ack_d;
  logic                en_rd_q, en_rd_d;
  logic                en_wr_q, en_wr_d;
  logic                busy_q, busy_d;
  logic                grant;
  logic                any_req;

  dm_arb_rr_pick u_pick (
    .req        ({p1_req, p0_req}),
    .last_grant (last_q),
    .grant      (grant),
    .any_req    (any_req)
  );

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= P_CPU;
      last_q  <= P_DMA;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      en_rd_q <= 1'b0;
      en_wr_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      en_rd_q <= en_rd_d;
      en_wr_q <= en_wr_d;
      busy_q  <= busy_d;
    end
  end

  // Next state plus next-cycle outputs, so registered outputs line up with state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    en_rd_d = 1'b0;
    en_wr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant;
          last_d  = grant;
          if (grant == P_DMA) begin
            we_d    = p1_we;
            addr_d  = p1_addr;
            wdata_d = p1_wdata;
          end else begin
            we_d    = p0_we;
            addr_d  = p0_addr;
            wdata_d = p0_wdata;
          end
          if (we_d) begin
            state_d      = WR;
            en_wr_d      = 1'b1;
            ack_d[grant] = 1'b1;
          end else begin
            state_d = RD0;
            en_rd_d = 1'b1;
          end
        end
      end
      WR:  state_d = IDLE;
      RD0: state_d = RD1;
      RD1: begin
        state_d        = RD2;
        ack_d[owner_q] = 1'b1;
      end
      RD2: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign p0_ack        = ack_q[0];
  assign p1_ack        = ack_q[1];
  assign DM_Address    = addr_q;
  assign DM_Write_Data = wdata_q;
  assign DM_en_Read    = en_rd_q;
  assign DM_en_Write   = en_wr_q;
  assign busy          = busy_q;

  // Read data is only valid from the DM during RD2, so it is steered through directly.
  assign p0_rdata = (state_q == RD2 && owner_q == P_CPU) ? DM_Read_Data : '0;
  assign p1_rdata = (state_q == RD2 && owner_q == P_DMA) ? DM_Read_Data : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: vector table, directed corner cases,
// and a randomized run against a transaction-level schedule model.
module tb_dm_arbiter;

  localparam int unsigned BW = 32;
  localparam int unsigned AW = 16;
`ifdef DM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [BW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack;
  logic [BW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] DM_Address;
  logic          DM_en_Read, DM_en_Write;
  logic [BW-1:0] DM_Write_Data, DM_Read_Data;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  dm_arbiter #(.bit_size(BW), .mem_size(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .p0_req        (p0_req),
    .p0_we         (p0_we),
    .p0_addr       (p0_addr),
    .p0_wdata      (p0_wdata),
    .p0_ack        (p0_ack),
    .p0_rdata      (p0_rdata),
    .p1_req        (p1_req),
    .p1_we         (p1_we),
    .p1_addr       (p1_addr),
    .p1_wdata      (p1_wdata),
    .p1_ack        (p1_ack),
    .p1_rdata      (p1_rdata),
    .DM_Address    (DM_Address),
    .DM_en_Read    (DM_en_Read),
    .DM_en_Write   (DM_en_Write),
    .DM_Write_Data (DM_Write_Data),
    .DM_Read_Data  (DM_Read_Data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: write commits at the edge, read is combinational from a registered address.
  logic [BW-1:0] dm_mem [0:(1<<AW)-1];
  logic [AW-1:0] dm_raddr;
  always @(posedge clk) begin
    if (DM_en_Write) dm_mem[DM_Address] <= DM_Write_Data;
    dm_raddr <= DM_Address;
  end
  assign DM_Read_Data = dm_mem[dm_raddr];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    int            gap;
    int            lat;
    logic [BW-1:0] rdata;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input logic p, input logic we, input logic [AW-1:0] a, input logic [BW-1:0] d);
    if (p) begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
    else   begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
  endtask

  task automatic drop_req(input logic p);
    if (p) p1_req = 1'b0;
    else   p0_req = 1'b0;
  endtask

  function automatic logic ack_of(input logic p);
    return p ? p1_ack : p0_ack;
  endfunction

  function automatic logic [BW-1:0] rdata_of(input logic p);
    return p ? p1_rdata : p0_rdata;
  endfunction

  function automatic logic req_of(input logic p);
    return p ? p1_req : p0_req;
  endfunction

  function automatic logic we_of(input logic p);
    return p ? p1_we : p0_we;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic p);
    return p ? p1_addr : p0_addr;
  endfunction

  function automatic logic [BW-1:0] wdata_of(input logic p);
    return p ? p1_wdata : p0_wdata;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_acks"}, 64'({p1_ack, p0_ack}), 64'(0));
    chk({tag, "_dm_en"}, 64'({DM_en_Read, DM_en_Write}), 64'(0));
    chk({tag, "_rdata"}, {p1_rdata, p0_rdata}, 64'(0));
  endtask

  task automatic do_reset();
    p0_req = 1'b0;
    p1_req = 1'b0;
    rst = 1'b0;
    #1;
    chk_idle_outputs("reset");
    chk("reset_dm_addr", 64'(DM_Address), 64'(0));
    chk("reset_dm_wdata", 64'(DM_Write_Data), 64'(0));
    tick();
    rst = 1'b1;
    tick();
  endtask

  // One single-port transaction from the vector table.
  task automatic do_txn(input int idx, input vec_t v);
    int  n, nrd, nwr, other;
    bit  got;
    n = 0; nrd = 0; nwr = 0; other = 0; got = 1'b0;
    repeat (v.gap) tick();
    set_req(v.port, v.we, v.addr, v.wdata);
    while (!got && n < 16) begin
      tick();
      n++;
      nrd += int'(DM_en_Read);
      nwr += int'(DM_en_Write);
      other += int'(ack_of(~v.port));
      if (ack_of(v.port)) begin
        got = 1'b1;
        if (!v.we) chk($sformatf("vec%0d_rdata", idx), 64'(rdata_of(v.port)), 64'(v.rdata));
        drop_req(v.port);
      end
    end
    if (!got) drop_req(v.port);
    chk($sformatf("vec%0d_latency", idx), 64'(got ? n : -1), 64'(v.lat));
    chk($sformatf("vec%0d_dm_en_read_cycles", idx), 64'(nrd), 64'(v.we ? 0 : 1));
    chk($sformatf("vec%0d_dm_en_write_cycles", idx), 64'(nwr), 64'(v.we ? 1 : 0));
    chk($sformatf("vec%0d_other_ack", idx), 64'(other), 64'(0));
  endtask

  // Run a fixed number of cycles with both requesters; optionally raise p1 late or hold reqs.
  task automatic run_multi(input int cycles, input int raise1_at, input bit hold,
                           output int first0, output int first1, output int cnt0, output int cnt1,
                           output logic [BW-1:0] rd0);
    first0 = -1; first1 = -1; cnt0 = 0; cnt1 = 0; rd0 = '0;
    for (int i = 1; i <= cycles; i++) begin
      tick();
      if (p0_ack) begin
        cnt0++;
        if (first0 < 0) begin first0 = i; rd0 = p0_rdata; end
        if (!hold) p0_req = 1'b0;
      end
      if (p1_ack) begin
        cnt1++;
        if (first1 < 0) first1 = i;
        if (!hold) p1_req = 1'b0;
      end
      if (i == raise1_at) p1_req = 1'b1;
    end
  endtask

  task automatic new_req(input logic p);
    set_req(p, 1'($urandom_range(1, 0)), 16'h0100 | AW'($urandom_range(15, 0)), $urandom());
  endtask

  // Randomized traffic checked against a grant-schedule model.
  task automatic random_phase(input int ncyc);
    int            exp_ack_t [2];
    logic          txn_we    [2];
    logic [BW-1:0] exp_rd    [2];
    logic [BW-1:0] ref_mem   [16];
    int            grant_t, free_at;
    logic          last, w, ea;
    logic [AW-1:0] a;
    exp_ack_t[0] = -10; exp_ack_t[1] = -10;
    txn_we[0] = 1'b0; txn_we[1] = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int k = 0; k < 16; k++) ref_mem[k] = '0;
    grant_t = -10; free_at = 0; last = 1'b1;
    for (int t = 0; t < ncyc; t++) begin
      for (int pi = 0; pi < 2; pi++) begin
        ea = (exp_ack_t[pi] == t);
        chk(pi ? "rnd_p1_ack" : "rnd_p0_ack", 64'(ack_of(1'(pi))), 64'(ea));
        chk(pi ? "rnd_p1_rdata" : "rnd_p0_rdata", 64'(rdata_of(1'(pi))),
            64'((ea && !txn_we[pi]) ? exp_rd[pi] : '0));
      end
      chk("rnd_busy", 64'(busy), 64'(t > grant_t && t < free_at));
      for (int pi = 0; pi < 2; pi++) begin
        if (exp_ack_t[pi] == t) begin
          drop_req(1'(pi));
          if ($urandom_range(1, 0) == 1) new_req(1'(pi));
        end else if (!req_of(1'(pi)) && $urandom_range(9, 0) < 3) begin
          new_req(1'(pi));
        end
      end
      if (t >= free_at && (p0_req || p1_req)) begin
        if (p0_req && p1_req) w = FIXED ? 1'b0 : ~last;
        else                  w = p1_req;
        last = w;
        grant_t = t;
        txn_we[w] = we_of(w);
        a = addr_of(w);
        if (txn_we[w]) begin
          ref_mem[a[3:0]] = wdata_of(w);
          exp_ack_t[w] = t + 1;
          free_at = t + 2;
        end else begin
          exp_rd[w] = ref_mem[a[3:0]];
          exp_ack_t[w] = t + 3;
          free_at = t + 4;
        end
      end
      tick();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (6) tick();
  endtask

  int            f0, f1, c0, c1;
  logic [BW-1:0] rd0;

  initial begin
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    for (int k = 0; k < (1 << AW); k++) dm_mem[k] = '0;

    vt.push_back('{1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 1, 1, 32'h0});
    vt.push_back('{1'b0, 1'b0, 16'h0010, 32'h0,        1, 3, 32'hDEADBEEF});
    vt.push_back('{1'b1, 1'b1, 16'h0000, 32'hA0000000, 1, 1, 32'h0});
    vt.push_back('{1'b1, 1'b1, 16'h0001, 32'hA0000001, 0, 2, 32'h0});
    vt.push_back('{1'b1, 1'b1, 16'h0002, 32'hA0000002, 0, 2, 32'h0});
    vt.push_back('{1'b1, 1'b1, 16'h0003, 32'hA0000003, 0, 2, 32'h0});
    vt.push_back('{1'b1, 1'b0, 16'h0000, 32'h0,        0, 4, 32'hA0000000});
    vt.push_back('{1'b1, 1'b0, 16'h0003, 32'h0,        1, 3, 32'hA0000003});
    vt.push_back('{1'b0, 1'b0, 16'h0002, 32'h0,        0, 4, 32'hA0000002});
    vt.push_back('{1'b0, 1'b1, 16'hFFFF, 32'h12345678, 2, 1, 32'h0});
    vt.push_back('{1'b1, 1'b0, 16'hFFFF, 32'h0,        1, 3, 32'h12345678});
    vt.push_back('{1'b0, 1'b0, 16'h0001, 32'h0,        0, 4, 32'hA0000001});

    tick();
    do_reset();
    foreach (vt[i]) do_txn(i, vt[i]);

    // Simultaneous requests straight after reset: port 0 wins the first tie.
    tick();
    do_reset();
    set_req(1'b0, 1'b0, 16'h0001, 32'h0);
    set_req(1'b1, 1'b1, 16'h0002, 32'h0BADF00D);
    run_multi(10, -1, 1'b0, f0, f1, c0, c1, rd0);
    chk("sim1_p0_ack_cycle", 64'(f0), 64'(3));
    chk("sim1_p1_ack_cycle", 64'(f1), 64'(5));
    chk("sim1_ack_counts", 64'({c0[7:0], c1[7:0]}), 64'(16'h0101));
    chk("sim1_p0_rdata", 64'(rd0), 64'(32'hA0000001));
    do_txn(100, '{1'b0, 1'b0, 16'h0002, 32'h0, 0, 3, 32'h0BADF00D});

    // Port 0 served alone, then a tie: round-robin now favours port 1.
    do_txn(101, '{1'b0, 1'b1, 16'h0004, 32'h44440004, 1, 1, 32'h0});
    tick();
    set_req(1'b0, 1'b1, 16'h0005, 32'h55550005);
    set_req(1'b1, 1'b1, 16'h0006, 32'h66660006);
    run_multi(8, -1, 1'b0, f0, f1, c0, c1, rd0);
    chk("sim2_p0_ack_cycle", 64'(f0), 64'(FIXED ? 1 : 3));
    chk("sim2_p1_ack_cycle", 64'(f1), 64'(FIXED ? 3 : 1));

    // Port 1 arrives during port 0's RD1 and is served right after RD2.
    tick();
    set_req(1'b0, 1'b0, 16'h0010, 32'h0);
    p1_we = 1'b1; p1_addr = 16'h0020; p1_wdata = 32'hCAFE0001;
    run_multi(10, 2, 1'b0, f0, f1, c0, c1, rd0);
    chk("busy_p0_ack_cycle", 64'(f0), 64'(3));
    chk("busy_p0_rdata", 64'(rd0), 64'(32'hDEADBEEF));
    chk("busy_p1_ack_cycle", 64'(f1), 64'(5));
    chk("busy_p1_ack_count", 64'(c1), 64'(1));
    do_txn(102, '{1'b1, 1'b0, 16'h0020, 32'h0, 0, 3, 32'hCAFE0001});

    // Reset while in RD1 aborts the read without an ack.
    tick();
    set_req(1'b0, 1'b0, 16'h0003, 32'h0);
    tick();
    tick();
    chk("rd1_busy_before_reset", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    chk_idle_outputs("rd1_reset");
    drop_req(1'b0);
    tick();
    chk_idle_outputs("rd1_reset_hold");
    rst = 1'b1;
    tick();
    chk_idle_outputs("rd1_after_reset");
    do_txn(103, '{1'b0, 1'b0, 16'h0003, 32'h0, 0, 3, 32'hA0000003});

    // Reset during WR: the write must not reach memory.
    tick();
    set_req(1'b1, 1'b1, 16'h0003, 32'hFFFF0000);
    tick();
    chk("wr_en_before_reset", 64'(DM_en_Write), 64'(1));
    rst = 1'b0;
    #1;
    chk_idle_outputs("wr_reset");
    drop_req(1'b1);
    tick();
    rst = 1'b1;
    tick();
    do_txn(104, '{1'b0, 1'b0, 16'h0003, 32'h0, 0, 3, 32'hA0000003});

    // Both ports requesting continuously.
    tick();
    do_reset();
    set_req(1'b0, 1'b1, 16'h0030, 32'h00000001);
    set_req(1'b1, 1'b1, 16'h0031, 32'h00000002);
    run_multi(40, -1, 1'b1, f0, f1, c0, c1, rd0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    chk("cont_p0_acks", 64'(c0), 64'(FIXED ? 20 : 10));
    chk("cont_p1_acks", 64'(c1), 64'(FIXED ? 0 : 10));
    chk("cont_p1_first", 64'(f1), 64'(FIXED ? -1 : 3));
    tick();
    tick();

    do_reset();
    random_phase(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
